// File: rtl/count_frame_tx.sv
// Snapshots two event counters on Capture and streams them as one byte-wide frame:
// HEADER, Count0 bytes (MSB first), Count1 bytes (MSB first), XOR checksum of the data bytes.
module count_frame_tx #(
  parameter int          WIDTH  = 64,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Count0,
  input  logic [WIDTH-1:0] Count1,
  input  logic             Capture,
  output logic [7:0]       Dout,
  output logic             Dout_valid,
  input  logic             Dout_ready,
  output logic             Dout_last,
  output logic             Busy,
  output logic             Drop
);

  localparam int NB = WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    C0   = 3'd2,
    C1   = 3'd3,
    SUM  = 3'd4
  } state_t;

  // cnt is the number of bytes of this word already sent, so byte NB-1-cnt goes next.
  function automatic logic [7:0] byte_sel(input logic [WIDTH-1:0] v, input logic [CW-1:0] cnt);
    logic [WIDTH-1:0] sh;
    sh = v >> (8 * (NB - 1 - int'(cnt)));
    return sh[7:0];
  endfunction

  function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t           state_r, state_nx;
  logic [CW-1:0]    cnt_r, cnt_nx;
  logic [WIDTH-1:0] snap0_r, snap1_r;
  logic [7:0]       csum_r, csum_nx;
  logic [7:0]       dout_r, dout_nx;
  logic             valid_r, valid_nx;
  logic             last_r, last_nx;
  logic             busy_r, busy_nx;
  logic             drop_r, drop_nx;
  logic             load_s;
  logic             xfer_s;

  assign xfer_s = valid_r && Dout_ready;

  // Next-state, next-output and checksum logic.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    csum_nx  = csum_r;
    dout_nx  = dout_r;
    valid_nx = valid_r;
    last_nx  = last_r;
    drop_nx  = 1'b0;
    load_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (Capture) begin
          load_s   = 1'b1;
          state_nx = HDR;
          cnt_nx   = {CW{1'b0}};
          csum_nx  = 8'h00;
          dout_nx  = HEADER;
          valid_nx = 1'b1;
          last_nx  = 1'b0;
        end else begin
          valid_nx = 1'b0;
          last_nx  = 1'b0;
        end
      end
      HDR: begin
        drop_nx = Capture;
        if (xfer_s) begin
          state_nx = C0;
          cnt_nx   = {CW{1'b0}};
          dout_nx  = byte_sel(snap0_r, {CW{1'b0}});
        end else begin
          state_nx = HDR;
        end
      end
      C0: begin
        drop_nx = Capture;
        if (xfer_s) begin
          csum_nx = xor_acc(csum_r, dout_r);
          if (cnt_r == CNT_LAST) begin
            state_nx = C1;
            cnt_nx   = {CW{1'b0}};
            dout_nx  = byte_sel(snap1_r, {CW{1'b0}});
          end else begin
            cnt_nx  = cnt_r + CW'(1'b1);
            dout_nx = byte_sel(snap0_r, cnt_r + CW'(1'b1));
          end
        end else begin
          state_nx = C0;
        end
      end
      C1: begin
        drop_nx = Capture;
        if (xfer_s) begin
          csum_nx = xor_acc(csum_r, dout_r);
          if (cnt_r == CNT_LAST) begin
            // Last data byte is folded in here so the checksum byte follows with no bubble.
            state_nx = SUM;
            cnt_nx   = {CW{1'b0}};
            dout_nx  = xor_acc(csum_r, dout_r);
            last_nx  = 1'b1;
          end else begin
            cnt_nx  = cnt_r + CW'(1'b1);
            dout_nx = byte_sel(snap1_r, cnt_r + CW'(1'b1));
          end
        end else begin
          state_nx = C1;
        end
      end
      SUM: begin
        drop_nx = Capture;
        if (xfer_s) begin
          state_nx = IDLE;
          dout_nx  = 8'h00;
          valid_nx = 1'b0;
          last_nx  = 1'b0;
        end else begin
          state_nx = SUM;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = {CW{1'b0}};
        dout_nx  = 8'h00;
        valid_nx = 1'b0;
        last_nx  = 1'b0;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // Control and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      csum_r  <= 8'h00;
      dout_r  <= 8'h00;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      csum_r  <= csum_nx;
      dout_r  <= dout_nx;
      valid_r <= valid_nx;
      last_r  <= last_nx;
      busy_r  <= busy_nx;
      drop_r  <= drop_nx;
    end
  end

  // Counter snapshot, frozen for the whole frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      snap0_r <= {WIDTH{1'b0}};
      snap1_r <= {WIDTH{1'b0}};
    end else if (load_s) begin
      snap0_r <= Count0;
      snap1_r <= Count1;
    end else begin
      snap0_r <= snap0_r;
      snap1_r <= snap1_r;
    end
  end

  assign Dout       = dout_r;
  assign Dout_valid = valid_r;
  assign Dout_last  = last_r;
  assign Busy       = busy_r;
  assign Drop       = drop_r;

endmodule

// File: tb/tb_count_frame_tx.sv
// Bench for count_frame_tx: table of frames checked through a byte scoreboard,
// plus hand sequences for dropped captures and mid-frame reset.
module tb_count_frame_tx;

  logic        Clk;
  logic        Reset;
  logic [63:0] Count0, Count1;
  logic        Capture;
  logic [7:0]  Dout;
  logic        Dout_valid;
  logic        Dout_ready;
  logic        Dout_last;
  logic        Busy;
  logic        Drop;

  count_frame_tx #(.WIDTH(64), .HEADER(8'hA5)) dut (
    .Clk(Clk), .Reset(Reset), .Count0(Count0), .Count1(Count1), .Capture(Capture),
    .Dout(Dout), .Dout_valid(Dout_valid), .Dout_ready(Dout_ready), .Dout_last(Dout_last),
    .Busy(Busy), .Drop(Drop)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    logic [63:0] c0;
    logic [63:0] c1;
    logic [7:0]  sum;
    int          bp_at;
    bit          inc;
    int          cycles;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[7];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ntx   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // One clock: observe a transfer at the falling edge, then land just after the rising edge.
  task automatic step();
    sb_t e;
    @(negedge Clk);
    if (Dout_valid && Dout_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_byte: got %02h, required no transfer", Dout);
      end else begin
        e = sb.pop_front();
        chk($sformatf("byte%0d_last_data", ntx), {55'd0, Dout_last, Dout}, {55'd0, e.last, e.data});
      end
      ntx++;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic push_frame(input logic [63:0] c0, input logic [63:0] c1, input logic [7:0] sum);
    sb.push_back({1'b0, 8'hA5});
    for (int i = 7; i >= 0; i--) sb.push_back({1'b0, c0[i*8 +: 8]});
    for (int i = 7; i >= 0; i--) sb.push_back({1'b0, c1[i*8 +: 8]});
    sb.push_back({1'b1, sum});
  endtask

  task automatic run_frame(input vec_t v);
    int base, cyc, held;
    logic [7:0] d;
    d = 8'h00;
    push_frame(v.c0, v.c1, v.sum);
    Count0 = v.c0;
    Count1 = v.c1;
    Dout_ready = 1'b1;
    Capture = 1'b1;
    step();
    Capture = 1'b0;
    base = ntx;
    chk("start_busy", {63'd0, Busy}, 64'd1);
    chk("start_header", {56'd0, Dout}, 64'hA5);
    cyc = 0;
    held = 0;
    while (Busy && cyc < 100) begin
      if (v.bp_at >= 0 && (ntx - base) == v.bp_at && held < 3) begin
        Dout_ready = 1'b0;
        d = Dout;
        held++;
      end else begin
        Dout_ready = 1'b1;
      end
      if (v.inc) begin
        Count0 = Count0 + 64'd1;
        Count1 = Count1 + 64'd1;
      end
      step();
      cyc++;
      if (!Dout_ready) begin
        chk("hold_data", {56'd0, Dout}, {56'd0, d});
        chk("hold_valid", {63'd0, Dout_valid}, 64'd1);
      end
    end
    Dout_ready = 1'b1;
    chk("frame_cycles", 64'(cyc), 64'(v.cycles));
    chk("end_valid", {63'd0, Dout_valid}, 64'd0);
    chk("end_last", {63'd0, Dout_last}, 64'd0);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int base, cyc;
    tbl[0] = '{64'h5, 64'h3, 8'h06, -1, 1'b0, 18};
    tbl[1] = '{64'h5, 64'h3, 8'h06,  4, 1'b0, 21};
    tbl[2] = '{64'h5, 64'h3, 8'h06, -1, 1'b1, 18};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, -1, 1'b0, 18};
    tbl[4] = '{64'h0123_4567_89AB_CDEF, 64'h0, 8'h00, -1, 1'b0, 18};
    tbl[5] = '{64'h0102_0304_0506_0708, 64'h80, 8'h88, -1, 1'b0, 18};
    tbl[6] = '{64'hFF00, 64'h1, 8'hFE, -1, 1'b0, 18};

    Reset = 1'b1;
    Capture = 1'b0;
    Dout_ready = 1'b1;
    Count0 = 64'd0;
    Count1 = 64'd0;
    #2;
    chk("rst_dout", {56'd0, Dout}, 64'd0);
    chk("rst_valid", {63'd0, Dout_valid}, 64'd0);
    chk("rst_last", {63'd0, Dout_last}, 64'd0);
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_drop", {63'd0, Drop}, 64'd0);
    step();
    step();
    Reset = 1'b0;
    step();
    chk("idle_valid", {63'd0, Dout_valid}, 64'd0);

    for (int i = 0; i < 7; i++) run_frame(tbl[i]);

    // Captures during a frame, including on the SUM-transfer edge, are dropped.
    push_frame(64'h5, 64'h3, 8'h06);
    Count0 = 64'h5;
    Count1 = 64'h3;
    Capture = 1'b1;
    step();
    Capture = 1'b0;
    base = ntx;
    cyc = 0;
    while ((ntx - base) != 6 && cyc < 100) begin step(); cyc++; end
    Capture = 1'b1;
    step();
    Capture = 1'b0;
    chk("drop_mid", {63'd0, Drop}, 64'd1);
    step();
    chk("drop_mid_clear", {63'd0, Drop}, 64'd0);
    while ((ntx - base) != 17 && cyc < 100) begin step(); cyc++; end
    chk("sum_last", {63'd0, Dout_last}, 64'd1);
    Capture = 1'b1;
    step();
    Capture = 1'b0;
    chk("drop_sum", {63'd0, Drop}, 64'd1);
    chk("drop_sum_busy", {63'd0, Busy}, 64'd0);
    chk("drop_sum_valid", {63'd0, Dout_valid}, 64'd0);
    push_frame(64'hA, 64'hB, 8'h01);
    Count0 = 64'hA;
    Count1 = 64'hB;
    Capture = 1'b1;
    step();
    Capture = 1'b0;
    chk("refire_drop", {63'd0, Drop}, 64'd0);
    chk("refire_busy", {63'd0, Busy}, 64'd1);
    chk("refire_header", {56'd0, Dout}, 64'hA5);
    cyc = 0;
    while (Busy && cyc < 100) begin step(); cyc++; end
    chk("refire_cycles", 64'(cyc), 64'd18);
    chk("refire_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of a frame aborts it immediately.
    push_frame(64'h5, 64'h3, 8'h06);
    Count0 = 64'h5;
    Count1 = 64'h3;
    Capture = 1'b1;
    step();
    Capture = 1'b0;
    base = ntx;
    cyc = 0;
    while ((ntx - base) != 9 && cyc < 100) begin step(); cyc++; end
    #2;
    Reset = 1'b1;
    #1;
    chk("abort_valid", {63'd0, Dout_valid}, 64'd0);
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    chk("abort_last", {63'd0, Dout_last}, 64'd0);
    chk("abort_dout", {56'd0, Dout}, 64'd0);
    sb.delete();
    step();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_abort_valid", {63'd0, Dout_valid}, 64'd0);
    end
    run_frame(tbl[6]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
